// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
// Access-type encodings, port indices, response state and the request bundle.
package mem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  localparam int unsigned PORT_LSU = 0;
  localparam int unsigned PORT_DBG = 1;

  typedef enum logic {StEmpty, StFull} resp_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  rw_type;
    logic [31:0] wdat;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the RAM-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface mem_arbiter_if;
  logic        req_0, req_1;
  logic        we_0, we_1;
  logic [31:0] addr_0, addr_1;
  logic [2:0]  rw_type_0, rw_type_1;
  logic [31:0] wdat_0, wdat_1;
  logic        gnt_0, gnt_1;
  logic        rvalid_0, rvalid_1;
  logic        rready_0, rready_1;
  logic [31:0] rdata_0, rdata_1;
  logic        rerr_0, rerr_1;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_rw_type;
  logic [31:0] mem_wdat;
  logic [31:0] mem_rdat;

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, rw_type_0, rw_type_1,
    input  wdat_0, wdat_1, rready_0, rready_1, mem_rdat,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, rerr_0, rerr_1,
    output mem_wr_en, mem_rd_en, mem_addr, mem_rw_type, mem_wdat
  );

  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, rw_type_0, rw_type_1,
    output wdat_0, wdat_1, rready_0, rready_1, mem_rdat,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata_0, rdata_1, rerr_0, rerr_1,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_rw_type, mem_wdat
  );
endinterface

// File: rtl/mem_req_check.sv
// Combinational legality screen for one RAM request: bad type, store to an
// unsigned-load type, misalignment, or address beyond the RAM window.
module mem_req_check
  import mem_pkg::*;
#(
  parameter int unsigned RAM_AW = 10
) (
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  rw_type,
  output logic        err
);

  always_comb begin
    err = 1'b0;
    unique case (rw_type)
      RW_B:    err = 1'b0;
      RW_H:    err = addr[0];
      RW_W:    err = |addr[1:0];
      RW_BU:   err = we;
      RW_HU:   err = we | addr[0];
      default: err = 1'b1;
    endcase
    if ((addr >> RAM_AW) != 32'd0) begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM. Grants one request per
// cycle, performs the access in the grant cycle and registers the response.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned RAM_AW    = 10,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  mem_req_t    port_req [2];
  logic [1:0]  req, rready, elig, gnt;
  resp_state_e state_q [2];
  resp_state_e state_d [2];
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic [1:0]  rerr_q, rerr_d;
  logic        last_q, last_d;
  logic        sel;
  mem_req_t    greq;
  logic        req_err;

  always_comb begin
    port_req[PORT_LSU] = '{we: bus.we_0, addr: bus.addr_0, rw_type: bus.rw_type_0,
                           wdat: bus.wdat_0};
    port_req[PORT_DBG] = '{we: bus.we_1, addr: bus.addr_1, rw_type: bus.rw_type_1,
                           wdat: bus.wdat_1};
  end

  assign req    = {bus.req_1, bus.req_0};
  assign rready = {bus.rready_1, bus.rready_0};

  // A full response slot frees up for a new grant in the cycle it drains.
  always_comb begin
    elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req[i] & ((state_q[i] == StEmpty) | rready[i]);
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (elig == 2'b11) begin
        if (PRIO_MODE == 1) begin
          gnt = 2'b01;
        end else begin
          gnt = last_q ? 2'b01 : 2'b10;
        end
      end else begin
        gnt = elig;
      end
    end
  end

  assign sel  = gnt[1];
  assign greq = port_req[sel];

  mem_req_check #(
    .RAM_AW (RAM_AW)
  ) u_check (
    .we      (greq.we),
    .addr    (greq.addr),
    .rw_type (greq.rw_type),
    .err     (req_err)
  );

  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_rw_type = '0;
    bus.mem_wdat    = '0;
    if (|gnt) begin
      bus.mem_wr_en   = greq.we & ~req_err;
      bus.mem_rd_en   = ~greq.we & ~req_err;
      bus.mem_addr    = greq.addr;
      bus.mem_rw_type = greq.rw_type;
      bus.mem_wdat    = greq.wdat;
    end
  end

  always_comb begin
    last_d = last_q;
    if (|gnt) begin
      last_d = sel;
    end
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      rdata_d[i] = rdata_q[i];
      rerr_d[i]  = rerr_q[i];
      if (gnt[i]) begin
        state_d[i] = StFull;
        rerr_d[i]  = req_err;
        rdata_d[i] = (!greq.we && !req_err) ? bus.mem_rdat : 32'd0;
      end else if ((state_q[i] == StFull) && rready[i]) begin
        state_d[i] = StEmpty;
      end
    end
  end

  // Pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StEmpty;
        rdata_q[i] <= '0;
      end
      rerr_q <= '0;
      last_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        rdata_q[i] <= rdata_d[i];
      end
      rerr_q <= rerr_d;
      last_q <= last_d;
    end
  end

  assign bus.gnt_0    = gnt[0];
  assign bus.gnt_1    = gnt[1];
  assign bus.rvalid_0 = (state_q[0] == StFull);
  assign bus.rvalid_1 = (state_q[1] == StFull);
  assign bus.rdata_0  = rdata_q[0];
  assign bus.rdata_1  = rdata_q[1];
  assign bus.rerr_0   = rerr_q[0];
  assign bus.rerr_1   = rerr_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all compared
// each cycle against a transaction-level model with its own shadow memory.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned RamAw = 10;

  logic        clk, rst_n;
  logic [1:0]  req, we, rready;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [2:0]  rwt [2];
  logic [1:0]  gnt, rvalid, rerr, gnt_p;
  logic [31:0] rdata [2];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] ram [256] = '{default: 32'd0};

  mem_arbiter_if bus ();
  mem_arbiter_if bus_p ();

  mem_arbiter #(.RAM_AW(RamAw), .PRIO_MODE(0)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_arbiter #(.RAM_AW(RamAw), .PRIO_MODE(1)) u_prio (.clk(clk), .rst_n(rst_n), .bus(bus_p));

  assign bus.req_0 = req[0];        assign bus.req_1 = req[1];
  assign bus.we_0 = we[0];          assign bus.we_1 = we[1];
  assign bus.addr_0 = addr[0];      assign bus.addr_1 = addr[1];
  assign bus.rw_type_0 = rwt[0];    assign bus.rw_type_1 = rwt[1];
  assign bus.wdat_0 = wdat[0];      assign bus.wdat_1 = wdat[1];
  assign bus.rready_0 = rready[0];  assign bus.rready_1 = rready[1];
  assign bus_p.req_0 = req[0];      assign bus_p.req_1 = req[1];
  assign bus_p.we_0 = we[0];        assign bus_p.we_1 = we[1];
  assign bus_p.addr_0 = addr[0];    assign bus_p.addr_1 = addr[1];
  assign bus_p.rw_type_0 = rwt[0];  assign bus_p.rw_type_1 = rwt[1];
  assign bus_p.wdat_0 = wdat[0];    assign bus_p.wdat_1 = wdat[1];
  assign bus_p.rready_0 = rready[0]; assign bus_p.rready_1 = rready[1];
  assign bus_p.mem_rdat = 32'd0;

  assign gnt    = {bus.gnt_1, bus.gnt_0};
  assign gnt_p  = {bus_p.gnt_1, bus_p.gnt_0};
  assign rvalid = {bus.rvalid_1, bus.rvalid_0};
  assign rerr   = {bus.rerr_1, bus.rerr_0};
  assign rdata[0] = bus.rdata_0;
  assign rdata[1] = bus.rdata_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] off, logic [2:0] t);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (t)
      RW_B:    return {{24{sh[7]}}, sh[7:0]};
      RW_BU:   return {24'd0, sh[7:0]};
      RW_H:    return {{16{sh[15]}}, sh[15:0]};
      RW_HU:   return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(logic [31:0] old, logic [1:0] off, logic [2:0] t,
                                            logic [31:0] d);
    logic [31:0] mask;
    case (t)
      RW_B:    mask = 32'h0000_00FF << (8 * off);
      RW_H:    mask = 32'h0000_FFFF << (8 * off);
      default: mask = 32'hFFFF_FFFF;
    endcase
    return (old & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  function automatic bit illegal(bit w, logic [31:0] a, logic [2:0] t);
    int size;
    bit bad_type;
    bad_type = !(t inside {RW_B, RW_H, RW_W, RW_BU, RW_HU});
    size = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
    return bad_type || (w && t[2]) || ((a % size) != 0) || (a >= 32'(1 << RamAw));
  endfunction

  // Environment RAM: combinational read, write at the clock edge.
  assign bus.mem_rdat = bus.mem_rd_en ?
      load_val(ram[bus.mem_addr[9:2]], bus.mem_addr[1:0], bus.mem_rw_type) : 32'd0;
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      ram[bus.mem_addr[9:2]] <= store_val(ram[bus.mem_addr[9:2]], bus.mem_addr[1:0],
                                          bus.mem_rw_type, bus.mem_wdat);
    end
  end

  // Reference model: per-port response slot, round-robin pointer, shadow memory.
  initial begin : model
    bit          m_full [2], n_full [2], m_rerr [2], n_rerr [2], el [2];
    logic [31:0] m_rdata [2], n_rdata [2];
    logic [31:0] shadow [256];
    int          m_ptr, n_ptr, g;
    bit          e, n_wr;
    logic [7:0]  n_idx;
    logic [31:0] n_word;
    for (int i = 0; i < 256; i++) shadow[i] = 32'd0;
    for (int p = 0; p < 2; p++) begin
      m_full[p] = 0; m_rerr[p] = 0; m_rdata[p] = 32'd0;
    end
    m_ptr = 1;
    forever begin
      @(negedge clk);
      n_wr = 0; n_idx = 8'd0; n_word = 32'd0;
      n_full = m_full; n_rerr = m_rerr; n_rdata = m_rdata; n_ptr = m_ptr;
      if (!rst_n) begin
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
        chk("rst_mem_en", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdat", bus.mem_wdat, 32'd0);
      end else begin
        g = -1;
        for (int p = 0; p < 2; p++) el[p] = req[p] && (!m_full[p] || rready[p]);
        if (el[0] && el[1]) g = (m_ptr == 0) ? 1 : 0;
        else if (el[0]) g = 0;
        else if (el[1]) g = 1;
        chk("gnt", {30'd0, gnt}, (g < 0) ? 32'd0 : 32'(1 << g));
        for (int p = 0; p < 2; p++) begin
          chk("rvalid", {31'd0, rvalid[p]}, {31'd0, m_full[p]});
          if (m_full[p]) begin
            chk("rdata", rdata[p], m_rdata[p]);
            chk("rerr", {31'd0, rerr[p]}, {31'd0, m_rerr[p]});
          end
          if (m_full[p] && rready[p]) n_full[p] = 0;
        end
        if (g < 0) begin
          chk("idle_mem_en", {30'd0, bus.mem_wr_en, bus.mem_rd_en}, 32'd0);
          chk("idle_mem_bus", bus.mem_addr | bus.mem_wdat | {29'd0, bus.mem_rw_type}, 32'd0);
        end else begin
          e = illegal(we[g], addr[g], rwt[g]);
          chk("mem_wr_en", {31'd0, bus.mem_wr_en}, {31'd0, we[g] && !e});
          chk("mem_rd_en", {31'd0, bus.mem_rd_en}, {31'd0, !we[g] && !e});
          chk("mem_addr", bus.mem_addr, addr[g]);
          chk("mem_rw_type", {29'd0, bus.mem_rw_type}, {29'd0, rwt[g]});
          chk("mem_wdat", bus.mem_wdat, wdat[g]);
          n_full[g] = 1;
          n_rerr[g] = e;
          n_rdata[g] = (!we[g] && !e) ?
              load_val(shadow[addr[g][9:2]], addr[g][1:0], rwt[g]) : 32'd0;
          n_ptr = g;
          if (we[g] && !e) begin
            n_wr = 1; n_idx = addr[g][9:2];
            n_word = store_val(shadow[n_idx], addr[g][1:0], rwt[g], wdat[g]);
          end
        end
      end
      @(posedge clk);
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) m_full[p] = 0;
        m_ptr = 1;
      end else begin
        m_full = n_full; m_rerr = n_rerr; m_rdata = n_rdata; m_ptr = n_ptr;
        if (n_wr) shadow[n_idx] = n_word;
      end
    end
  end

  task automatic wait_gnt(input int p);
    bit got;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[p]) got = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input int p, input bit w, input logic [31:0] a, input logic [2:0] t,
                     input logic [31:0] d, output logic [31:0] rd, output bit re);
    req[p] = 1'b1; we[p] = w; addr[p] = a; rwt[p] = t; wdat[p] = d; rready[p] = 1'b1;
    wait_gnt(p);
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
    chk("resp_latency", {31'd0, rvalid[p]}, 32'd1);
    rd = rdata[p];
    re = rerr[p];
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, hold;
    bit          re;
    logic [1:0]  gs;
    rst_n = 1'b0; req = '0; we = '0; rready = '1;
    for (int p = 0; p < 2; p++) begin
      addr[p] = 32'd0; wdat[p] = 32'd0; rwt[p] = RW_W;
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Both ports request every cycle: alternation vs fixed priority.
    req = 2'b11; addr[0] = 32'h0; addr[1] = 32'h4;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_gnt0", {31'd0, gnt[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("prio_gnt", {30'd0, gnt_p}, 32'd1);
      @(posedge clk); #1;
    end
    req = 2'b00;
    @(posedge clk); #1;

    txn(0, 1'b1, 32'h10, RW_W, 32'hDEADBEEF, rd, re);
    chk("sw_rerr", {31'd0, re}, 32'd0);
    txn(0, 1'b0, 32'h10, RW_W, 32'd0, rd, re);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_rerr", {31'd0, re}, 32'd0);

    txn(1, 1'b1, 32'h10, RW_W, 32'h80FF0000, rd, re);
    txn(1, 1'b0, 32'h13, RW_B, 32'd0, rd, re);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    txn(1, 1'b0, 32'h13, RW_BU, 32'd0, rd, re);
    chk("lbu_rdata", rd, 32'h00000080);

    txn(0, 1'b0, 32'h12, RW_W, 32'd0, rd, re);
    chk("err_lw_mis", {rd[30:0], re}, 32'd1);
    txn(0, 1'b1, 32'h11, RW_H, 32'h1111, rd, re);
    chk("err_sh_mis", {rd[30:0], re}, 32'd1);
    txn(0, 1'b1, 32'h10, RW_BU, 32'h22, rd, re);
    chk("err_sbu", {rd[30:0], re}, 32'd1);
    txn(0, 1'b0, 32'h400, RW_W, 32'd0, rd, re);
    chk("err_range", {rd[30:0], re}, 32'd1);
    txn(0, 1'b0, 32'h10, RW_W, 32'd0, rd, re);
    chk("ram_unchanged", rd, 32'h80FF0000);

    // Response held with rready_0 low while port 1 is served.
    req = 2'b11; we = 2'b00; rwt[0] = RW_W; rwt[1] = RW_W;
    addr[0] = 32'h10; addr[1] = 32'h14; rready = 2'b10;
    wait_gnt(0);
    @(posedge clk); #1;
    @(negedge clk);
    hold = rdata[0];
    chk("hold_first", hold, 32'h80FF0000);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_rvalid", {31'd0, rvalid[0]}, 32'd1);
      chk("hold_rdata", rdata[0], hold);
      chk("hold_gnt", {30'd0, gnt}, 32'd2);
      @(posedge clk); #1;
    end
    rready = 2'b11;
    @(negedge clk);
    chk("resume_gnt", {30'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Reset pulse in the middle of a port 1 store grant.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; rwt[1] = RW_W; wdat[1] = 32'h12345678;
    wait_gnt(1);
    #2 rst_n = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20; rwt[0] = RW_W;
    @(posedge clk); #1;
    chk("rstp_rvalid", {30'd0, rvalid}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstp_tie", {30'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("rstp_nowrite", rdata[0], 32'd0);
    chk("rstp_regnt", {30'd0, gnt}, 32'd2);
    @(posedge clk); #1;
    req[1] = 1'b0;
    txn(0, 1'b0, 32'h20, RW_W, 32'd0, rd, re);
    chk("rstp_replay", rd, 32'h12345678);

    // Random traffic; requests held until granted.
    gs = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gs = gnt;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || gs[p]) begin
          req[p] = ($urandom_range(0, 3) != 0);
          we[p] = $urandom_range(0, 1) == 1;
          case ($urandom_range(0, 7))
            0: rwt[p] = 3'($urandom_range(0, 7));
            1, 2: rwt[p] = RW_B;
            3: rwt[p] = RW_H;
            4, 5: rwt[p] = RW_W;
            6: rwt[p] = RW_BU;
            default: rwt[p] = RW_HU;
          endcase
          addr[p] = 32'($urandom_range(0, 31));
          if ($urandom_range(0, 15) == 0) addr[p] = addr[p] | (32'd1 << $urandom_range(10, 31));
          wdat[p] = $urandom;
        end
        rready[p] = ($urandom_range(0, 3) != 0);
      end
    end
    req = 2'b00; rready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 (load/store unit) and port 1 (debug/loader port).
- Per port: req/gnt request handshake, then a registered response with rvalid/rready.
- Screens every request for illegal type, misalignment and out-of-range address, and returns an error response instead of touching the RAM.
- Drives the RAM's wr_en/rd_en/addr/rw_type/dat_i and captures its combinational read data.

Parameters:
- RAM_AW, 10, byte-address bits covered by the RAM (256 words); any set bit in addr[31:RAM_AW] is out of range.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with port 0 winning.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_0 / req_1  in  1  request valid; held stable until gnt.
- we_0 / we_1  in  1  request is a store (1) or load (0).
- addr_0 / addr_1  in  32  byte address.
- rw_type_0 / rw_type_1  in  3  access type: 000 b, 001 h, 010 w, 100 bu (load only), 101 hu (load only).
- wdat_0 / wdat_1  in  32  store data, right-aligned.
- gnt_0 / gnt_1  out  1  request accepted this cycle (combinational).
- rvalid_0 / rvalid_1  out  1  response valid.
- rready_0 / rready_1  in  1  requester accepts the response.
- rdata_0 / rdata_1  out  32  load data; 0 for stores and errors.
- rerr_0 / rerr_1  out  1  request was rejected.
- mem_wr_en  out  1  RAM write enable.
- mem_rd_en  out  1  RAM read enable.
- mem_addr  out  32  RAM address.
- mem_rw_type  out  3  RAM access type.
- mem_wdat  out  32  RAM write data.
- mem_rdat  in  32  RAM read data (combinational, already extended).

Behaviour:
- Reset values: rvalid_x=0, rdata_x=0, rerr_x=0, last-grant pointer=1 so port 0 wins the first tie. All mem_* outputs and gnt_x are 0 while rst_n=0.
- Per-port response FSM: EMPTY, FULL.
  - Port x is eligible when req_x=1 and (state EMPTY, or FULL with rready_x=1).
  - A drained response may be replaced by a new grant in the same cycle, giving back-to-back throughput.
- Arbitration (combinational, every cycle):
  - One eligible port: it is granted.
  - Both eligible, PRIO_MODE=0: grant the port that is not the last-grant pointer.
  - Both eligible, PRIO_MODE=1: grant port 0.
  - At most one gnt per cycle.
  - The pointer updates to the granted port at the clock edge.
- Legality check on the granted request; any failure sets err:
  - rw_type is 011, 110 or 111.
  - we=1 with rw_type 100 or 101.
  - Halfword access (x01) with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr[31:RAM_AW]≠0.
- Access cycle equals the grant cycle:
  - mem_addr, mem_rw_type and mem_wdat come from the granted port.
  - mem_rd_en = gnt & ~we & ~err.
  - mem_wr_en = gnt & we & ~err; the write commits at the same edge.
  - With no grant, all mem_* outputs are 0.
- Response, at the edge after a grant to port x:
  - rvalid_x=1.
  - rerr_x = err.
  - rdata_x = mem_rdat for a legal load, else 0.
  - State goes to FULL.
- Response hold: while rvalid_x=1 and rready_x=0, rvalid_x, rdata_x and rerr_x stay stable and port x gets no grant.
- Response drain: on rvalid_x & rready_x with no new grant to x, state goes to EMPTY and rvalid_x=0 at the next edge.
- Latency: 1 cycle from grant to rvalid. Throughput is one access per cycle across both ports.
- Simultaneous events: a port being drained can be granted in the same cycle; the other port's pending response is unaffected.
- Reset mid-operation: responses are dropped and no write occurs at an edge where rst_n=0. A request held through reset is re-arbitrated after release.

Decomposition:
- Shared package mem_pkg holds:
  - rw_type constants RW_B=3'b000, RW_H=3'b001, RW_W=3'b010, RW_BU=3'b100, RW_HU=3'b101.
  - Port index constants PORT_LSU=0, PORT_DBG=1.
- One combinational sub-module, mem_req_check: inputs we, addr, rw_type, RAM_AW; output err. It is instantiated once, on the muxed granted request.

Test Plan:
- Port 0 stores word 0xDEADBEEF to addr 0x10, then loads 0x10 (w) → gnt_0 both times; load's rvalid_0 one cycle after gnt with rdata_0=0xDEADBEEF, rerr_0=0.
- Both ports request every cycle, rready=1, PRIO_MODE=0 → grants alternate 0,1,0,1 starting with port 0; PRIO_MODE=1 → port 0 every cycle and port 1 never granted.
- Port 1 lb from addr 0x13 after word 0x80FF0000 stored at 0x10 → rdata_1=0xFFFFFF80; lbu → 0x00000080.
- Port 0 lw at 0x12, sh at 0x11, sb with rw_type 100, lw at 0x400 → each gives rerr_0=1, rdata_0=0, mem_wr_en/mem_rd_en never 1, RAM contents unchanged.
- Port 0 holds rready_0=0 for 3 cycles with req_0 held → rvalid_0/rdata_0 stable; port 0 not re-granted while port 1 is served; grant resumes in the cycle rready_0 rises.
- rst_n pulsed low during a port 1 store grant → no RAM write at that edge; all rvalid=0; first post-reset tie goes to port 0.
